// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types.
// Contents:
//   excp_t       - fetch/execute exception codes
//   ibuf_entry_t - one instruction-buffer slot: pc, instruction word,
//                  branch prediction and fetch exception
package cpu_pkg;

  typedef enum logic [3:0] {
    EXCP_NONE = 4'd0,
    EXCP_INT  = 4'd1,
    EXCP_ADEF = 4'd2,
    EXCP_TLBR = 4'd3,
    EXCP_PIF  = 4'd4,
    EXCP_PPI  = 4'd5,
    EXCP_SYS  = 4'd6,
    EXCP_BRK  = 4'd7,
    EXCP_INE  = 4'd8,
    EXCP_ALE  = 4'd9
  } excp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_br_taken;
    logic [31:0] pred_br_target;
    logic        have_excp;
    excp_t       excp_type;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: decoupling queue between instruction fetch and the two
// decoder lanes.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   flush                - drop every entry (takes effect at next edge)
//   in_valid[1:0]        - fetch slot valid (slot 1 requires slot 0)
//   in_entry0/1          - fetch payloads, slot 0 older
//   in_ready             - at least two free entries
//   out_valid[1:0]       - head / head+1 valid
//   out_entry0/1         - head / head+1 payloads
//   out_accept[1:0]      - decode consumes lane 0 / lanes 0 and 1
//   count                - current occupancy
module inst_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  input  ibuf_entry_t                in_entry0,
  input  ibuf_entry_t                in_entry1,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output ibuf_entry_t                out_entry0,
  output ibuf_entry_t                out_entry1,
  input  logic [1:0]                 out_accept,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinct.
  localparam int PW = AW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          pop0, pop1;

  logic [AW-1:0] head_idx, head1_idx;
  logic [AW-1:0] tail_idx, tail1_idx;

  // Flat register storage; not reset, validity is tracked by count.
  ibuf_entry_t   mem_q [DEPTH];

  // Index arithmetic on the low bits wraps modulo DEPTH for free.
  always_comb begin
    head_idx  = head_q[AW-1:0];
    head1_idx = head_q[AW-1:0] + AW'(1);
    tail_idx  = tail_q[AW-1:0];
    tail1_idx = tail_q[AW-1:0] + AW'(1);
  end

  // Status outputs come from registered count only, so no input reaches
  // an output combinationally (in_ready ignores same-cycle pops).
  always_comb begin
    in_ready     = (count_q <= PW'(DEPTH - 2));
    out_valid[0] = (count_q != '0);
    out_valid[1] = (count_q >= PW'(2));
    count        = count_q;
    out_entry0   = mem_q[head_idx];
    out_entry1   = mem_q[head1_idx];
  end

  // Push / pop amounts. in_valid == 2'b10 pushes nothing because slot 0
  // gates both slots.
  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid[0]) begin
      push_n = in_valid[1] ? 2'd2 : 2'd1;
    end
    // Lane 1 only counts when lane 0 is also consumed.
    pop0  = out_accept[0] & out_valid[0];
    pop1  = pop0 & out_accept[1] & out_valid[1];
    pop_n = {1'b0, pop0} + {1'b0, pop1};
  end

  // Next-state pointers; flush wins over any push or pop that cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + PW'(push_n) - PW'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Two write ports; tail and tail+1 never alias since DEPTH >= 4.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) begin
      mem_q[tail_idx] <= in_entry0;
    end
    if (!flush && push_n == 2'd2) begin
      mem_q[tail1_idx] <= in_entry1;
    end
  end

  // Slot 1 valid without slot 0 is a fetch-side protocol error.
  a_in_valid_legal: assert property (
    @(posedge clk) disable iff (!resetn) in_valid != 2'b10
  );

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        in_valid = 2'b00;
  ibuf_entry_t       in_entry0 = '0;
  ibuf_entry_t       in_entry1 = '0;
  logic              in_ready;
  logic [1:0]        out_valid;
  ibuf_entry_t       out_entry0;
  ibuf_entry_t       out_entry1;
  logic [1:0]        out_accept = 2'b00;
  logic [PW-1:0]     count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: a plain FIFO of entries, oldest at index 0.
  ibuf_entry_t mq[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_entry0  (in_entry0),
    .in_entry1  (in_entry1),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_entry0 (out_entry0),
    .out_entry1 (out_entry1),
    .out_accept (out_accept),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic ibuf_entry_t mk(input logic [31:0] pc);
    ibuf_entry_t e;
    e.pc             = pc;
    e.inst           = $urandom;
    e.pred_br_taken  = 1'($urandom_range(0, 1));
    e.pred_br_target = $urandom;
    e.have_excp      = 1'($urandom_range(0, 1));
    e.excp_type      = e.have_excp ? EXCP_ADEF : EXCP_NONE;
    return e;
  endfunction

  // One clock: drive inputs, advance the model by the queue rules, wait
  // for the edge, sample point is the following falling edge.
  task automatic cycle(input logic fl, input logic [1:0] v,
                       input ibuf_entry_t e0, input ibuf_entry_t e1,
                       input logic [1:0] acc);
    int n;
    bit rdy;
    flush = fl; in_valid = v; in_entry0 = e0; in_entry1 = e1; out_accept = acc;
    n   = mq.size();
    rdy = (DEPTH - n) >= 2;
    if (fl) begin
      mq.delete();
    end else begin
      if (acc[0] && n >= 1) begin
        mq.delete(0);
        if (acc[1] && n >= 2) mq.delete(0);
      end
      if (rdy && v[0]) begin
        mq.push_back(e0);
        if (v[1]) mq.push_back(e1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    $display("cyc %0d flush=%0d in_valid=%b accept=%b -> count=%0d out_valid=%b in_ready=%0d",
             cyc, fl, v, acc, count, out_valid, in_ready);
    flush = 1'b0; in_valid = 2'b00; out_accept = 2'b00;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    mq.delete();
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 2'b00 || count !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: out_valid=%b count=%0d in_ready=%0d want 00/0/1", out_valid, count, in_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 2'b00 || count !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: out_valid=%b count=%0d in_ready=%0d want 00/0/1", out_valid, count, in_ready);
    end
    cycle(1'b0, 2'b01, mk(BASE), mk(32'h0), 2'b00);
    total++;
    if (out_valid !== 2'b01 || out_entry0 !== mq[0] || out_entry0.pc !== BASE) begin
      bad++;
      $display("FAIL single_push: out_valid=%b pc=%h want 01 pc=%h", out_valid, out_entry0.pc, BASE);
    end
  endtask

  task automatic test_fill();
    cycle(1'b1, 2'b00, mk(0), mk(0), 2'b00);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'b11, mk(BASE + 32'(8 * i)), mk(BASE + 32'(8 * i + 4)), 2'b00);
      if (i == 2) begin
        total++;
        if (count !== PW'(6) || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL fill_3: count=%0d in_ready=%0d want 6/1", count, in_ready);
        end
      end
    end
    total++;
    if (count !== PW'(8) || in_ready !== 1'b0 || out_valid !== 2'b11) begin
      bad++;
      $display("FAIL fill_full: count=%0d in_ready=%0d out_valid=%b want 8/0/11", count, in_ready, out_valid);
    end
    cycle(1'b0, 2'b11, mk(32'hdead_0000), mk(32'hdead_0004), 2'b00);
    total++;
    if (count !== PW'(8) || out_entry0.pc !== BASE) begin
      bad++;
      $display("FAIL fill_ignored: count=%0d pc=%h want 8 pc=%h", count, out_entry0.pc, BASE);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_entry0.pc !== BASE + 32'(8 * i) || out_entry1.pc !== BASE + 32'(8 * i + 4) ||
          out_entry0 !== mq[0] || out_entry1 !== mq[1]) begin
        bad++;
        $display("FAIL drain_%0d: pc0=%h pc1=%h want %h %h", i, out_entry0.pc, out_entry1.pc,
                 BASE + 32'(8 * i), BASE + 32'(8 * i + 4));
      end
      cycle(1'b0, 2'b00, mk(0), mk(0), 2'b11);
    end
    total++;
    if (count !== '0 || out_valid !== 2'b00) begin
      bad++;
      $display("FAIL drain_empty: count=%0d out_valid=%b want 0/00", count, out_valid);
    end
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 2'b00, mk(0), mk(0), 2'b00);
    cycle(1'b0, 2'b11, mk(BASE), mk(BASE + 4), 2'b00);
    cycle(1'b0, 2'b11, mk(BASE + 8), mk(BASE + 12), 2'b00);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2'b11, mk(BASE + 32'(16 + 8 * i)), mk(BASE + 32'(20 + 8 * i)), 2'b11);
      total++;
      if (count !== PW'(4) || out_entry0.pc !== BASE + 32'(8 * (i + 1)) ||
          out_entry1.pc !== BASE + 32'(8 * (i + 1) + 4) || out_entry0 !== mq[0]) begin
        bad++;
        $display("FAIL push_pop_%0d: count=%0d pc0=%h pc1=%h want 4 %h %h", i, count,
                 out_entry0.pc, out_entry1.pc, BASE + 32'(8 * (i + 1)), BASE + 32'(8 * (i + 1) + 4));
      end
    end
  endtask

  task automatic test_accepts();
    cycle(1'b1, 2'b00, mk(0), mk(0), 2'b00);
    cycle(1'b0, 2'b01, mk(32'h100), mk(0), 2'b00);
    cycle(1'b0, 2'b00, mk(0), mk(0), 2'b11);
    total++;
    if (count !== '0 || out_valid !== 2'b00) begin
      bad++;
      $display("FAIL masked_accept: count=%0d out_valid=%b want 0/00", count, out_valid);
    end
    cycle(1'b0, 2'b11, mk(32'h200), mk(32'h204), 2'b00);
    cycle(1'b0, 2'b01, mk(32'h208), mk(0), 2'b00);
    cycle(1'b0, 2'b00, mk(0), mk(0), 2'b01);
    total++;
    if (count !== PW'(2) || out_entry0.pc !== 32'h204 || out_entry1.pc !== 32'h208 ||
        out_entry0 !== mq[0]) begin
      bad++;
      $display("FAIL single_accept: count=%0d pc0=%h pc1=%h want 2 204 208", count, out_entry0.pc, out_entry1.pc);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 2'b00, mk(0), mk(0), 2'b00);
    cycle(1'b0, 2'b11, mk(32'h300), mk(32'h304), 2'b00);
    cycle(1'b0, 2'b11, mk(32'h308), mk(32'h30c), 2'b00);
    cycle(1'b0, 2'b01, mk(32'h310), mk(0), 2'b00);
    cycle(1'b1, 2'b11, mk(32'h314), mk(32'h318), 2'b11);
    total++;
    if (count !== '0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_priority: count=%0d out_valid=%b in_ready=%0d want 0/00/1", count, out_valid, in_ready);
    end
    cycle(1'b0, 2'b01, mk(32'h400), mk(0), 2'b00);
    total++;
    if (count !== PW'(1) || out_valid !== 2'b01 || out_entry0 !== mq[0] || out_entry0.pc !== 32'h400) begin
      bad++;
      $display("FAIL flush_then_push: count=%0d pc=%h want 1 pc=400", count, out_entry0.pc);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 2'b00, mk(0), mk(0), 2'b00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, mk(32'h500 + 32'(8 * i)), mk(32'h504 + 32'(8 * i)), 2'b00);
    total++;
    if (count !== PW'(6)) begin
      bad++;
      $display("FAIL async_pre: count=%0d want 6", count);
    end
    #2 resetn = 1'b0;
    mq.delete();
    #1;
    total++;
    if (out_valid !== 2'b00 || count !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: out_valid=%b count=%0d in_ready=%0d want 00/0/1", out_valid, count, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 2'b00 || count !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_release: out_valid=%b count=%0d in_ready=%0d want 00/0/1", out_valid, count, in_ready);
    end
    cycle(1'b0, 2'b01, mk(BASE), mk(0), 2'b00);
    total++;
    if (out_valid !== 2'b01 || out_entry0.pc !== BASE) begin
      bad++;
      $display("FAIL async_push: out_valid=%b pc=%h want 01 pc=%h", out_valid, out_entry0.pc, BASE);
    end
  endtask

  task automatic test_random();
    logic [1:0] v, acc;
    logic fl;
    logic [31:0] pc = 32'h2000_0000;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      case ($urandom_range(0, 3))
        0: acc = 2'b00;
        1: acc = 2'b01;
        default: acc = 2'b11;
      endcase
      fl = ($urandom_range(0, 19) == 0);
      cycle(fl, v, mk(pc), mk(pc + 4), acc);
      pc = pc + 8;
      total++;
      if (count !== PW'(mq.size()) || out_valid !== {mq.size() >= 2, mq.size() >= 1} ||
          in_ready !== ((DEPTH - mq.size()) >= 2)) begin
        bad++;
        $display("FAIL rand_status_%0d: count=%0d out_valid=%b in_ready=%0d want count=%0d", i,
                 count, out_valid, in_ready, mq.size());
      end
      if (mq.size() >= 1) begin
        total++;
        if (out_entry0 !== mq[0]) begin
          bad++;
          $display("FAIL rand_entry0_%0d: pc=%h want pc=%h", i, out_entry0.pc, mq[0].pc);
        end
      end
      if (mq.size() >= 2) begin
        total++;
        if (out_entry1 !== mq[1]) begin
          bad++;
          $display("FAIL rand_entry1_%0d: pc=%h want pc=%h", i, out_entry1.pc, mq[1].pc);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_push_pop();
    test_accepts();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
